reg_rename_file: RTL and testbench
==================================

REG_RENAME_FILE -- requirements
Module: reg_rename_file

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 The module SHALL have parameter REG_COUNT, default 32, number of architectural registers; index 0 is hardwired zero.
REQ-003 The module SHALL have parameter ROB_TAG_WIDTH, default 4, ROB tag width; tag 0 means "no pending producer".
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ena  in  1  global enable; when low, all state holds and reads stay valid.
REQ-007 in_commit_reg  in  log2(REG_COUNT)  committed destination register; 0 means no commit.
REQ-008 in_commit_rob  in  ROB_TAG_WIDTH  ROB tag of the committing entry.
REQ-009 in_commit_value  in  DATA_WIDTH  committed result value.
REQ-010 in_rename_ena  in  1  dispatch is renaming a destination this cycle.
REQ-011 in_rename_reg  in  log2(REG_COUNT)  destination register being renamed.
REQ-012 in_rename_rob  in  ROB_TAG_WIDTH  ROB tag allocated to that destination.
REQ-013 in_flush  in  1  misbranch flush pulse; discards all speculative renames.
REQ-014 in_query_reg1, in_query_reg2  in  log2(REG_COUNT)  source operand register indices.
REQ-015 out_value1, out_value2  out  DATA_WIDTH  architectural value of each queried register.
REQ-016 out_tag1, out_tag2  out  ROB_TAG_WIDTH  pending producer tag of each queried register; 0 when none.
REQ-017 out_pending_count  out  log2(REG_COUNT)+1  number of registers currently holding a non-zero tag.

Function
REQ-018 Read ports SHALL be combinational: value and tag of the queried register from current state; register 0 always returns value 0, tag 0.
REQ-019 On commit with in_commit_reg != 0, value[reg] SHALL be written next edge regardless of tag.
REQ-020 On commit, tag[reg] SHALL be cleared to 0 only if tag[reg] == in_commit_rob; a newer rename (mismatched tag) SHALL be kept.
REQ-021 On rename with in_rename_reg != 0 and no flush, tag[reg] SHALL become in_rename_rob next edge.
REQ-022 Rename and commit to the same register in one cycle: value SHALL take in_commit_value, tag SHALL take in_rename_rob (rename wins).
REQ-023 On in_flush, every tag SHALL become 0 next edge, that cycle's rename SHALL be ignored, and that cycle's commit value write SHALL still occur.
REQ-024 out_pending_count SHALL be a registered counter updated incrementally: +1 on rename of an untagged register, -1 on a tag-clearing commit, net 0 when both hit the same register; forced to 0 on flush.
REQ-025 Writes or renames targeting register 0 SHALL have no effect on any state or the counter.
REQ-026 When ena is low, commit, rename and flush SHALL be ignored.

Reset
REQ-027 On rst, all values, all tags and out_pending_count SHALL become 0 at the next edge; rst overrides ena, flush, commit and rename.
REQ-028 Reset asserted mid-operation SHALL discard that cycle's commit and rename.

Configuration
REQ-029 With COMMIT_BYPASS_EN defined, a read port whose register equals in_commit_reg (non-zero) SHALL return in_commit_value, and SHALL return tag 0 when the current tag equals in_commit_rob.
REQ-030 Without COMMIT_BYPASS_EN, read ports SHALL reflect registered state only; the commit becomes visible one cycle later.

Structure
REQ-031 DATA_WIDTH, ROB_TAG_WIDTH, zero-tag constant and register-index width SHALL live in the shared constants package used by the ROB and decoder.
REQ-032 One sub-module, rename_read_port, SHALL implement a single read port (lookup, x0 masking, optional bypass), instantiated twice.

Verification
REQ-033 Reset, then query x5 -> value 0, tag 0, pending_count 0.
REQ-034 Rename x5 with tag 3, next cycle commit x5/tag 3/value 0x1234 -> after edge x5 value 0x1234, tag 0, count back to 0.
REQ-035 Rename x5 tag 3, then rename x5 tag 7, then commit x5/tag 3/value 0xAA -> value 0xAA, tag stays 7, count 1.
REQ-036 Rename x1 tag 2, x2 tag 4, then flush with concurrent commit x1/tag 2/value 9 and rename x3 tag 5 -> all tags 0, x1 = 9, x3 untagged, count 0.
REQ-037 Commit x0 value 0xFFFF and rename x0 tag 6 -> x0 reads 0, tag 0, count unchanged.
REQ-038 With COMMIT_BYPASS_EN, x7 tagged 4, commit x7/tag 4/value 0x55 while querying x7 -> same cycle value 0x55, tag 0; without it -> old value, tag 4 that cycle.

Source files
------------

// File: rtl/reg_rename_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_rename_file_pkg
// Description : Shared constants for the rename file, ROB and decoder:
//               default data / register-count / ROB-tag widths, the
//               "no pending producer" tag value and the register-index
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_rename_file_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 32;
  localparam int unsigned DEF_REG_COUNT     = 32;
  localparam int unsigned DEF_ROB_TAG_WIDTH = 4;

  // Tag value meaning "register value is architectural, nothing in flight".
  localparam int unsigned ZERO_TAG = 0;

  // Width of a register index; never narrower than one bit.
  function automatic int unsigned reg_idx_width(input int unsigned count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rename_read_port.sv
`default_nettype none
// ============================================================================
// Module      : rename_read_port
// Description : One combinational read port of the rename file. Looks up the
//               value and pending tag of the queried register, forces x0 to
//               value 0 / tag 0 and, when COMMIT_BYPASS_EN is defined,
//               forwards a same-cycle commit to the reader.
// Ports       : i_values / i_tags      - full register state
//               i_query_reg            - register index to read
//               i_commit_vld           - a commit to a non-zero reg is live
//               i_commit_reg/rob/value - that commit's fields
//               o_value / o_tag        - read result
// Config      : COMMIT_BYPASS_EN - enable same-cycle commit forwarding
// Revision    : 1.0 - initial release
// ============================================================================
module rename_read_port
  import reg_rename_file_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter  int unsigned REG_COUNT     = DEF_REG_COUNT,
  parameter  int unsigned ROB_TAG_WIDTH = DEF_ROB_TAG_WIDTH,
  localparam int unsigned IDX_W         = reg_idx_width(REG_COUNT)
) (
  input  logic [REG_COUNT-1:0][DATA_WIDTH-1:0]    i_values,
  input  logic [REG_COUNT-1:0][ROB_TAG_WIDTH-1:0] i_tags,
  input  logic [IDX_W-1:0]                        i_query_reg,
  input  logic                                    i_commit_vld,
  input  logic [IDX_W-1:0]                        i_commit_reg,
  input  logic [ROB_TAG_WIDTH-1:0]                i_commit_rob,
  input  logic [DATA_WIDTH-1:0]                   i_commit_value,
  output logic [DATA_WIDTH-1:0]                   o_value,
  output logic [ROB_TAG_WIDTH-1:0]                o_tag
);

  localparam logic [ROB_TAG_WIDTH-1:0] C_ZERO_TAG = ROB_TAG_WIDTH'(ZERO_TAG);

`ifndef COMMIT_BYPASS_EN
  logic w_unused_bypass;
  assign w_unused_bypass = ^{i_commit_vld, i_commit_reg, i_commit_rob, i_commit_value};
`endif

  always_comb begin
    o_value = i_values[i_query_reg];
    o_tag   = i_tags[i_query_reg];
`ifdef COMMIT_BYPASS_EN
    // The commit lands in the array at the next edge; show it now. The tag
    // only drops if this commit is the register's latest producer.
    if (i_commit_vld && (i_commit_reg == i_query_reg)) begin
      o_value = i_commit_value;
      if (o_tag == i_commit_rob) begin
        o_tag = C_ZERO_TAG;
      end
    end
`endif
    if (i_query_reg == '0) begin
      o_value = '0;
      o_tag   = C_ZERO_TAG;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_rename_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_rename_file
// Description : Architectural register file with per-register pending ROB
//               tag (register renaming status). Commits write values and
//               retire matching tags, dispatch renames set tags, a flush
//               drops every pending tag. Two combinational read ports.
// Ports       : clk, rst (sync, active-high), ena (global enable)
//               in_commit_reg/rob/value - commit (reg 0 = none)
//               in_rename_ena/reg/rob   - destination rename
//               in_flush                - drop all speculative renames
//               in_query_reg1/2         - read indices
//               out_value1/2, out_tag1/2 - read results
//               out_pending_count       - number of tagged registers
// Config      : COMMIT_BYPASS_EN - read ports forward the same-cycle commit
// Revision    : 1.0 - initial release
// ============================================================================
module reg_rename_file
  import reg_rename_file_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter  int unsigned REG_COUNT     = DEF_REG_COUNT,
  parameter  int unsigned ROB_TAG_WIDTH = DEF_ROB_TAG_WIDTH,
  localparam int unsigned IDX_W         = reg_idx_width(REG_COUNT),
  localparam int unsigned CNT_W         = IDX_W + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic [IDX_W-1:0]         in_commit_reg,
  input  logic [ROB_TAG_WIDTH-1:0] in_commit_rob,
  input  logic [DATA_WIDTH-1:0]    in_commit_value,
  input  logic                     in_rename_ena,
  input  logic [IDX_W-1:0]         in_rename_reg,
  input  logic [ROB_TAG_WIDTH-1:0] in_rename_rob,
  input  logic                     in_flush,
  input  logic [IDX_W-1:0]         in_query_reg1,
  input  logic [IDX_W-1:0]         in_query_reg2,
  output logic [DATA_WIDTH-1:0]    out_value1,
  output logic [DATA_WIDTH-1:0]    out_value2,
  output logic [ROB_TAG_WIDTH-1:0] out_tag1,
  output logic [ROB_TAG_WIDTH-1:0] out_tag2,
  output logic [CNT_W-1:0]         out_pending_count
);

  localparam logic [ROB_TAG_WIDTH-1:0] C_ZERO_TAG = ROB_TAG_WIDTH'(ZERO_TAG);

  logic [REG_COUNT-1:0][DATA_WIDTH-1:0]    r_value;
  logic [REG_COUNT-1:0][ROB_TAG_WIDTH-1:0] r_tag;
  logic [CNT_W-1:0]                        r_pending_count;

  logic                     w_commit_vld;
  logic                     w_rename_vld;
  logic                     w_commit_clear;
  logic                     w_inc;
  logic                     w_dec_rename;
  logic                     w_dec_commit;
  logic                     w_bypass_vld;
  logic [ROB_TAG_WIDTH-1:0] w_commit_old_tag;
  logic [ROB_TAG_WIDTH-1:0] w_rename_old_tag;

  always_comb begin
    w_commit_vld     = ena && (in_commit_reg != '0);
    w_rename_vld     = ena && in_rename_ena && !in_flush && (in_rename_reg != '0);
    w_commit_old_tag = r_tag[in_commit_reg];
    w_rename_old_tag = r_tag[in_rename_reg];
    // A commit only retires the tag if it is still the newest producer.
    w_commit_clear   = w_commit_vld && !in_flush &&
                       (w_commit_old_tag == in_commit_rob) &&
                       (w_commit_old_tag != C_ZERO_TAG);
    // Count tracks actual zero/non-zero tag transitions so it can never
    // drift from the tag array.
    w_inc        = w_rename_vld && (w_rename_old_tag == C_ZERO_TAG) &&
                   (in_rename_rob != C_ZERO_TAG);
    w_dec_rename = w_rename_vld && (w_rename_old_tag != C_ZERO_TAG) &&
                   (in_rename_rob == C_ZERO_TAG);
    // Same-register rename overrides the clear, so the commit's -1 vanishes.
    w_dec_commit = w_commit_clear &&
                   !(w_rename_vld && (in_rename_reg == in_commit_reg));
    w_bypass_vld = w_commit_vld && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value         <= '0;
      r_tag           <= '0;
      r_pending_count <= '0;
    end else if (ena) begin
      if (w_commit_vld) begin
        r_value[in_commit_reg] <= in_commit_value;
      end
      if (in_flush) begin
        r_tag           <= '0;
        r_pending_count <= '0;
      end else begin
        if (w_commit_clear) begin
          r_tag[in_commit_reg] <= C_ZERO_TAG;
        end
        // Issued after the clear so a same-register rename wins.
        if (w_rename_vld) begin
          r_tag[in_rename_reg] <= in_rename_rob;
        end
        r_pending_count <= r_pending_count + CNT_W'(w_inc)
                           - CNT_W'(w_dec_rename) - CNT_W'(w_dec_commit);
      end
    end
  end

  assign out_pending_count = r_pending_count;

  rename_read_port #(
    .DATA_WIDTH   (DATA_WIDTH),
    .REG_COUNT    (REG_COUNT),
    .ROB_TAG_WIDTH(ROB_TAG_WIDTH)
  ) u_read_port1 (
    .i_values      (r_value),
    .i_tags        (r_tag),
    .i_query_reg   (in_query_reg1),
    .i_commit_vld  (w_bypass_vld),
    .i_commit_reg  (in_commit_reg),
    .i_commit_rob  (in_commit_rob),
    .i_commit_value(in_commit_value),
    .o_value       (out_value1),
    .o_tag         (out_tag1)
  );

  rename_read_port #(
    .DATA_WIDTH   (DATA_WIDTH),
    .REG_COUNT    (REG_COUNT),
    .ROB_TAG_WIDTH(ROB_TAG_WIDTH)
  ) u_read_port2 (
    .i_values      (r_value),
    .i_tags        (r_tag),
    .i_query_reg   (in_query_reg2),
    .i_commit_vld  (w_bypass_vld),
    .i_commit_reg  (in_commit_reg),
    .i_commit_rob  (in_commit_rob),
    .i_commit_value(in_commit_value),
    .o_value       (out_value2),
    .o_tag         (out_tag2)
  );

endmodule
`default_nettype wire

// File: tb/tb_reg_rename_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_rename_file
// Description : Self-checking bench for reg_rename_file: directed scenarios
//               plus randomized traffic against an array-based model.
//               Honours COMMIT_BYPASS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_rename_file;

  localparam int DW = 32;
  localparam int RC = 32;
  localparam int TW = 4;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic [IW-1:0] commit_reg;
  logic [TW-1:0] commit_rob;
  logic [DW-1:0] commit_value;
  logic          rename_ena;
  logic [IW-1:0] rename_reg;
  logic [TW-1:0] rename_rob;
  logic          flush;
  logic [IW-1:0] q1;
  logic [IW-1:0] q2;
  logic [DW-1:0] value1;
  logic [DW-1:0] value2;
  logic [TW-1:0] tag1;
  logic [TW-1:0] tag2;
  logic [IW:0]   count;

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural values and pending tags.
  logic [DW-1:0] m_val[RC];
  logic [TW-1:0] m_tag[RC];

  always #5 clk = ~clk;

  reg_rename_file dut (
    .clk              (clk),
    .rst              (rst),
    .ena              (ena),
    .in_commit_reg    (commit_reg),
    .in_commit_rob    (commit_rob),
    .in_commit_value  (commit_value),
    .in_rename_ena    (rename_ena),
    .in_rename_reg    (rename_reg),
    .in_rename_rob    (rename_rob),
    .in_flush         (flush),
    .in_query_reg1    (q1),
    .in_query_reg2    (q2),
    .out_value1       (value1),
    .out_value2       (value2),
    .out_tag1         (tag1),
    .out_tag2         (tag2),
    .out_pending_count(count)
  );

  task automatic idle();
    ena          = 1'b1;
    commit_reg   = '0;
    commit_rob   = '0;
    commit_value = '0;
    rename_ena   = 1'b0;
    rename_reg   = '0;
    rename_rob   = '0;
    flush        = 1'b0;
  endtask

  // One clock edge; the model applies the rules to the inputs in force.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < RC; i++) begin
        m_val[i] = '0;
        m_tag[i] = '0;
      end
    end else if (ena) begin
      if (commit_reg != 0) m_val[commit_reg] = commit_value;
      if (flush) begin
        for (int i = 0; i < RC; i++) m_tag[i] = '0;
      end else begin
        if (commit_reg != 0 && m_tag[commit_reg] == commit_rob) m_tag[commit_reg] = '0;
        if (rename_ena && rename_reg != 0) m_tag[rename_reg] = rename_rob;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] exp_value(input logic [IW-1:0] q);
    logic [DW-1:0] v;
    v = (q == 0) ? '0 : m_val[q];
`ifdef COMMIT_BYPASS_EN
    if (!rst && ena && q != 0 && q == commit_reg) v = commit_value;
`endif
    return v;
  endfunction

  function automatic logic [TW-1:0] exp_tag(input logic [IW-1:0] q);
    logic [TW-1:0] t;
    t = (q == 0) ? '0 : m_tag[q];
`ifdef COMMIT_BYPASS_EN
    if (!rst && ena && q != 0 && q == commit_reg && t == commit_rob) t = '0;
`endif
    return t;
  endfunction

  function automatic logic [IW:0] exp_count();
    int n;
    n = 0;
    for (int i = 1; i < RC; i++) if (m_tag[i] != 0) n++;
    return (IW+1)'(n);
  endfunction

  task automatic test_reset();
    idle();
    rst = 1'b1;
    q1 = 5'd5;
    q2 = 5'd0;
    tick();
    tick();
    rst = 1'b0;
    #2;
    checks++; if (value1 !== 32'h0) begin failures++; $display("FAIL reset_value got=%0h exp=0", value1); end
    checks++; if (tag1 !== 4'h0) begin failures++; $display("FAIL reset_tag got=%0h exp=0", tag1); end
    checks++; if (count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
  endtask

  task automatic test_commit_clear();
    do_reset();
    q1 = 5'd5;
    rename_ena = 1'b1; rename_reg = 5'd5; rename_rob = 4'd3;
    tick();
    idle();
    #2;
    checks++; if (tag1 !== 4'd3) begin failures++; $display("FAIL rename_tag got=%0d exp=3", tag1); end
    checks++; if (count !== 6'd1) begin failures++; $display("FAIL rename_count got=%0d exp=1", count); end
    commit_reg = 5'd5; commit_rob = 4'd3; commit_value = 32'h1234;
    tick();
    idle();
    #2;
    checks++; if (value1 !== 32'h1234) begin failures++; $display("FAIL commit_value got=%0h exp=1234", value1); end
    checks++; if (tag1 !== 4'd0) begin failures++; $display("FAIL commit_tag got=%0d exp=0", tag1); end
    checks++; if (count !== 6'd0) begin failures++; $display("FAIL commit_count got=%0d exp=0", count); end
  endtask

  task automatic test_stale_commit();
    do_reset();
    q1 = 5'd5;
    rename_ena = 1'b1; rename_reg = 5'd5; rename_rob = 4'd3;
    tick();
    rename_rob = 4'd7;
    tick();
    idle();
    commit_reg = 5'd5; commit_rob = 4'd3; commit_value = 32'hAA;
    tick();
    idle();
    #2;
    checks++; if (value1 !== 32'hAA) begin failures++; $display("FAIL stale_value got=%0h exp=aa", value1); end
    checks++; if (tag1 !== 4'd7) begin failures++; $display("FAIL stale_tag got=%0d exp=7", tag1); end
    checks++; if (count !== 6'd1) begin failures++; $display("FAIL stale_count got=%0d exp=1", count); end
  endtask

  task automatic test_flush();
    do_reset();
    rename_ena = 1'b1; rename_reg = 5'd1; rename_rob = 4'd2;
    tick();
    rename_reg = 5'd2; rename_rob = 4'd4;
    tick();
    flush = 1'b1;
    commit_reg = 5'd1; commit_rob = 4'd2; commit_value = 32'd9;
    rename_reg = 5'd3; rename_rob = 4'd5;
    tick();
    idle();
    q1 = 5'd1; q2 = 5'd3;
    #2;
    checks++; if (value1 !== 32'd9) begin failures++; $display("FAIL flush_commit_value got=%0h exp=9", value1); end
    checks++; if (tag1 !== 4'd0) begin failures++; $display("FAIL flush_tag_x1 got=%0d exp=0", tag1); end
    checks++; if (tag2 !== 4'd0) begin failures++; $display("FAIL flush_tag_x3 got=%0d exp=0", tag2); end
    checks++; if (count !== 6'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    q2 = 5'd2;
    #2;
    checks++; if (tag2 !== 4'd0) begin failures++; $display("FAIL flush_tag_x2 got=%0d exp=0", tag2); end
  endtask

  task automatic test_x0();
    do_reset();
    rename_ena = 1'b1; rename_reg = 5'd4; rename_rob = 4'd6;
    tick();
    commit_reg = 5'd0; commit_value = 32'hFFFF;
    rename_reg = 5'd0; rename_rob = 4'd6;
    tick();
    idle();
    q1 = 5'd0; q2 = 5'd4;
    #2;
    checks++; if (value1 !== 32'h0) begin failures++; $display("FAIL x0_value got=%0h exp=0", value1); end
    checks++; if (tag1 !== 4'd0) begin failures++; $display("FAIL x0_tag got=%0d exp=0", tag1); end
    checks++; if (count !== 6'd1) begin failures++; $display("FAIL x0_count got=%0d exp=1", count); end
    checks++; if (tag2 !== 4'd6) begin failures++; $display("FAIL x0_other_tag got=%0d exp=6", tag2); end
  endtask

  task automatic test_bypass();
    do_reset();
    rename_ena = 1'b1; rename_reg = 5'd7; rename_rob = 4'd4;
    tick();
    idle();
    q1 = 5'd7;
    commit_reg = 5'd7; commit_rob = 4'd4; commit_value = 32'h55;
    #2;
`ifdef COMMIT_BYPASS_EN
    checks++; if (value1 !== 32'h55) begin failures++; $display("FAIL bypass_value got=%0h exp=55", value1); end
    checks++; if (tag1 !== 4'd0) begin failures++; $display("FAIL bypass_tag got=%0d exp=0", tag1); end
`else
    checks++; if (value1 !== 32'h0) begin failures++; $display("FAIL nobypass_value got=%0h exp=0", value1); end
    checks++; if (tag1 !== 4'd4) begin failures++; $display("FAIL nobypass_tag got=%0d exp=4", tag1); end
`endif
    tick();
    idle();
    #2;
    checks++; if (value1 !== 32'h55) begin failures++; $display("FAIL post_commit_value got=%0h exp=55", value1); end
    checks++; if (tag1 !== 4'd0) begin failures++; $display("FAIL post_commit_tag got=%0d exp=0", tag1); end
  endtask

  task automatic test_ena_low();
    do_reset();
    rename_ena = 1'b1; rename_reg = 5'd9; rename_rob = 4'd3;
    tick();
    idle();
    ena = 1'b0;
    commit_reg = 5'd9; commit_rob = 4'd3; commit_value = 32'h77;
    rename_ena = 1'b1; rename_reg = 5'd11; rename_rob = 4'd5;
    flush = 1'b1;
    tick();
    idle();
    q1 = 5'd9; q2 = 5'd11;
    #2;
    checks++; if (value1 !== 32'h0) begin failures++; $display("FAIL ena_low_value got=%0h exp=0", value1); end
    checks++; if (tag1 !== 4'd3) begin failures++; $display("FAIL ena_low_tag got=%0d exp=3", tag1); end
    checks++; if (tag2 !== 4'd0) begin failures++; $display("FAIL ena_low_rename got=%0d exp=0", tag2); end
    checks++; if (count !== 6'd1) begin failures++; $display("FAIL ena_low_count got=%0d exp=1", count); end
  endtask

  task automatic test_rst_midop();
    do_reset();
    commit_reg = 5'd10; commit_value = 32'h21;
    rename_ena = 1'b1; rename_reg = 5'd10; rename_rob = 4'd2;
    tick();
    idle();
    rst = 1'b1;
    commit_reg = 5'd10; commit_rob = 4'd2; commit_value = 32'h33;
    rename_ena = 1'b1; rename_reg = 5'd12; rename_rob = 4'd1;
    tick();
    rst = 1'b0;
    idle();
    q1 = 5'd10; q2 = 5'd12;
    #2;
    checks++; if (value1 !== 32'h0) begin failures++; $display("FAIL rst_mid_value got=%0h exp=0", value1); end
    checks++; if (tag1 !== 4'd0) begin failures++; $display("FAIL rst_mid_tag got=%0d exp=0", tag1); end
    checks++; if (tag2 !== 4'd0) begin failures++; $display("FAIL rst_mid_rename got=%0d exp=0", tag2); end
    checks++; if (count !== 6'd0) begin failures++; $display("FAIL rst_mid_count got=%0d exp=0", count); end
  endtask

  task automatic test_random();
    logic [DW-1:0] ev;
    logic [TW-1:0] et;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 49) == 0);
      ena          = ($urandom_range(0, 9) != 0);
      flush        = ($urandom_range(0, 19) == 0);
      commit_reg   = ($urandom_range(0, 3) == 0) ? '0 : IW'($urandom_range(0, 7));
      commit_rob   = ($urandom_range(0, 1) == 1) ? m_tag[commit_reg] : TW'($urandom_range(1, 15));
      commit_value = $urandom;
      rename_ena   = ($urandom_range(0, 1) == 1);
      rename_reg   = IW'($urandom_range(0, 7));
      rename_rob   = TW'($urandom_range(1, 15));
      q1           = ($urandom_range(0, 2) == 0) ? commit_reg : IW'($urandom_range(0, 7));
      q2           = IW'($urandom_range(0, RC-1));
      #2;
      ev = exp_value(q1);
      et = exp_tag(q1);
      checks++; if (value1 !== ev) begin failures++; $display("FAIL rand_value1 cyc=%0d q=%0d got=%0h exp=%0h", i, q1, value1, ev); end
      checks++; if (tag1 !== et) begin failures++; $display("FAIL rand_tag1 cyc=%0d q=%0d got=%0d exp=%0d", i, q1, tag1, et); end
      ev = exp_value(q2);
      et = exp_tag(q2);
      checks++; if (value2 !== ev) begin failures++; $display("FAIL rand_value2 cyc=%0d q=%0d got=%0h exp=%0h", i, q2, value2, ev); end
      checks++; if (tag2 !== et) begin failures++; $display("FAIL rand_tag2 cyc=%0d q=%0d got=%0d exp=%0d", i, q2, tag2, et); end
      checks++; if (count !== exp_count()) begin failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", i, count, exp_count()); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    q1  = '0;
    q2  = '0;
    idle();
    test_reset();
    test_commit_clear();
    test_stale_commit();
    test_flush();
    test_x0();
    test_bypass();
    test_ena_low();
    test_rst_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
